// File: rtl/param_stack.sv
// LIFO stack with a registered pop result, occupancy flags and sticky overflow/underflow errors.
// Optional build macro PARAM_STACK_PEEK_EN adds a combinational peek port showing the current top entry.
module param_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       clr_err,
  output logic [WIDTH-1:0]           stack_EX_DM,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf,
  output logic                       unf
`ifdef PARAM_STACK_PEEK_EN
  ,
  output logic [WIDTH-1:0]           peek
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] dout_reg, dout_next;
  logic             ovf_reg, ovf_next;
  logic             unf_reg, unf_next;

  logic             op_push, op_pop, op_both;
  logic             is_full, is_empty;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    top_idx;
  logic [WIDTH-1:0] top_data;

  assign op_push  = push & ~pop;
  assign op_pop   = pop & ~push;
  assign op_both  = push & pop;

  // Flags come only from the count register, never from push/pop.
  assign is_full  = (count_reg == CW'(DEPTH));
  assign is_empty = (count_reg == '0);

  // When empty this index wraps to a stale slot; every consumer masks it with is_empty.
  assign top_idx  = AW'(count_reg - CW'(1));
  assign top_data = mem[top_idx];

  always_comb begin
    count_next = count_reg;
    dout_next  = dout_reg;
    ovf_next   = clr_err ? 1'b0 : ovf_reg;
    unf_next   = clr_err ? 1'b0 : unf_reg;
    wr_en      = 1'b0;
    wr_addr    = AW'(count_reg);

    if (op_push) begin
      if (!is_full) begin
        wr_en      = 1'b1;
        count_next = count_reg + CW'(1);
      end else begin
        ovf_next   = 1'b1;
      end
    end else if (op_pop) begin
      if (!is_empty) begin
        dout_next  = top_data;
        count_next = count_reg - CW'(1);
      end else begin
        dout_next  = '0;
        unf_next   = 1'b1;
      end
    end else if (op_both) begin
      // Replace the top in place; on an empty stack the write passes straight through.
      if (!is_empty) begin
        dout_next = top_data;
        wr_en     = 1'b1;
        wr_addr   = top_idx;
      end else begin
        dout_next = wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
      dout_reg  <= '0;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      dout_reg  <= dout_next;
      ovf_reg   <= ovf_next;
      unf_reg   <= unf_next;
    end
  end

  // Storage carries no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wdata;
    end
  end

  assign stack_EX_DM = dout_reg;
  assign count       = count_reg;
  assign full        = is_full;
  assign empty       = is_empty;
  assign ovf         = ovf_reg;
  assign unf         = unf_reg;

`ifdef PARAM_STACK_PEEK_EN
  assign peek = is_empty ? '0 : top_data;
`endif

endmodule

// File: tb/tb_param_stack.sv
// Scoreboard bench for param_stack (WIDTH=32, DEPTH=4): a queue-based LIFO model predicts each cycle's outputs.
// Expected results are queued when stimulus is driven and compared after the clock edge.
module tb_param_stack;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic [WIDTH-1:0] wdata = '0;
  logic             clr_err = 1'b0;
  logic [WIDTH-1:0] stack_EX_DM;
  logic [CW-1:0]    count;
  logic             full, empty, ovf, unf;
`ifdef PARAM_STACK_PEEK_EN
  logic [WIDTH-1:0] peek;
`endif

  param_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .pop         (pop),
    .wdata       (wdata),
    .clr_err     (clr_err),
    .stack_EX_DM (stack_EX_DM),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .ovf         (ovf),
    .unf         (unf)
`ifdef PARAM_STACK_PEEK_EN
    ,
    .peek        (peek)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] dout;
    int               cnt;
    logic             ovf;
    logic             unf;
    logic [WIDTH-1:0] top;
  } exp_t;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] mstack[$];
  logic [WIDTH-1:0] m_dout = '0;
  logic             m_ovf  = 1'b0;
  logic             m_unf  = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    mstack.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  // Drive one cycle, predict its outcome, then compare once the edge has passed.
  task automatic step(input logic p, input logic q, input logic [WIDTH-1:0] d, input logic c);
    exp_t e;
    logic set_o, set_u;
    set_o = 1'b0;
    set_u = 1'b0;
    push = p; pop = q; wdata = d; clr_err = c;
    if (p && !q) begin
      if (mstack.size() < DEPTH) mstack.push_back(d);
      else set_o = 1'b1;
    end else if (q && !p) begin
      if (mstack.size() > 0) m_dout = mstack.pop_back();
      else begin
        m_dout = '0;
        set_u  = 1'b1;
      end
    end else if (p && q) begin
      if (mstack.size() > 0) begin
        m_dout = mstack[mstack.size()-1];
        mstack[mstack.size()-1] = d;
      end else begin
        m_dout = d;
      end
    end
    m_ovf = set_o ? 1'b1 : (c ? 1'b0 : m_ovf);
    m_unf = set_u ? 1'b1 : (c ? 1'b0 : m_unf);
    e.dout = m_dout;
    e.cnt  = mstack.size();
    e.ovf  = m_ovf;
    e.unf  = m_unf;
    e.top  = (mstack.size() > 0) ? mstack[mstack.size()-1] : '0;
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; clr_err = 1'b0;

    if (exp_q.size() == 0) begin
      check_eq("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      $display("txn push=%0b pop=%0b clr=%0b wdata=%h -> dout=%h count=%0d full=%0b empty=%0b ovf=%0b unf=%0b",
               p, q, c, d, stack_EX_DM, count, full, empty, ovf, unf);
      check_eq("dout",  stack_EX_DM, e.dout);
      check_eq("count", 32'(count), 32'(e.cnt));
      check_eq("full",  32'(full),  32'(e.cnt == DEPTH));
      check_eq("empty", 32'(empty), 32'(e.cnt == 0));
      check_eq("ovf",   32'(ovf),   32'(e.ovf));
      check_eq("unf",   32'(unf),   32'(e.unf));
`ifdef PARAM_STACK_PEEK_EN
      check_eq("peek",  peek, e.top);
`endif
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #2;
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_dout",  stack_EX_DM, 32'd0);
    check_eq("rst_empty", 32'(empty), 32'd1);
    check_eq("rst_flags", 32'({ovf, unf}), 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();

    // Push three, pop three: reverse order out
    step(1, 0, 32'h11, 0);
    step(1, 0, 32'h22, 0);
    step(1, 0, 32'h33, 0);
    step(0, 1, 32'h0, 0);
    check_eq("lifo_1", stack_EX_DM, 32'h33);
    step(0, 1, 32'h0, 0);
    check_eq("lifo_2", stack_EX_DM, 32'h22);
    step(0, 1, 32'h0, 0);
    check_eq("lifo_3", stack_EX_DM, 32'h11);
    check_eq("lifo_empty", 32'(empty), 32'd1);

    // Overflow after five pushes, then drain
    for (int i = 0; i < 5; i++) step(1, 0, 32'h100 + 32'(i), 0);
    check_eq("ovf_set", 32'(ovf), 32'd1);
    check_eq("ovf_full", 32'(full), 32'd1);
    step(1, 1, 32'hF00D, 0);
    check_eq("both_full_ovf", 32'(ovf), 32'd1);
    for (int i = 0; i < 4; i++) step(0, 1, 32'h0, 0);

    // Underflow then clear
    step(0, 1, 32'h0, 1);
    step(0, 1, 32'h0, 0);
    check_eq("unf_set", 32'(unf), 32'd1);
    step(0, 0, 32'h0, 1);
    check_eq("unf_clr", 32'(unf), 32'd0);

    // Set wins over simultaneous clear
    step(0, 1, 32'h0, 1);
    check_eq("set_wins", 32'(unf), 32'd1);
    step(0, 0, 32'h0, 1);

    // Push+pop on non-empty and empty stacks
    step(1, 0, 32'hA, 0);
    step(1, 1, 32'hB, 0);
    check_eq("pp_old_top", stack_EX_DM, 32'hA);
    step(0, 1, 32'h0, 0);
    check_eq("pp_new_top", stack_EX_DM, 32'hB);
    step(1, 1, 32'hC, 0);
    check_eq("pp_pass", stack_EX_DM, 32'hC);
    check_eq("pp_pass_unf", 32'(unf), 32'd0);

    // Peek tracks the top combinationally
    step(1, 0, 32'hDEAD, 0);
    step(0, 1, 32'h0, 0);

    // Asynchronous reset mid-operation
    step(1, 0, 32'h1, 0);
    step(1, 0, 32'h2, 0);
    step(0, 1, 32'h0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 32'h50 + 32'(i), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_count", 32'(count), 32'd0);
    check_eq("arst_dout",  stack_EX_DM, 32'd0);
    check_eq("arst_ovf",   32'(ovf), 32'd0);
    check_eq("arst_unf",   32'(unf), 32'd0);
    model_reset();
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(0, 1, 32'h0, 0);
    check_eq("post_rst_unf", 32'(unf), 32'd1);

    // Random traffic
    for (int i = 0; i < 200; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(),
           1'($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
